// File: rtl/bure_core_pkg.sv
// -----------------------------------------------------------------------------
// bure_core_pkg
// Core-wide constants shared by the Bure pipeline stages.
//   INSTR_BYTES      : size of one instruction word in bytes (PC step).
//   DEFAULT_RESET_PC : address of the first fetch after reset.
// -----------------------------------------------------------------------------
package bure_core_pkg;

    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage : bure_core_pkg

// File: rtl/bure_stage_interface_pkg.sv
// -----------------------------------------------------------------------------
// bure_stage_interface_pkg
// Field widths of the inter-stage interfaces of the Bure pipeline.
//   IF_PC_WIDTH    : width of the pc field carried from fetch to decode.
//   IF_INSTR_WIDTH : width of the instr field carried from fetch to decode.
// -----------------------------------------------------------------------------
package bure_stage_interface_pkg;

    localparam int IF_PC_WIDTH    = 32;
    localparam int IF_INSTR_WIDTH = 32;

endpackage : bure_stage_interface_pkg

// File: rtl/bure_if_interface.sv
// -----------------------------------------------------------------------------
// bure_if_interface
// Fetch -> decode handoff.
//   instr       : fetched instruction word at the head of the fetch queue.
//   instr_valid : instr/pc are meaningful this cycle.
//   pc          : address the instruction was fetched from.
// master = fetch stage (drives), slave = decode stage (observes).
// Flow control back to fetch travels as a separate stall signal.
// -----------------------------------------------------------------------------
interface bure_if_interface #(
    parameter int DATA_WIDTH  = bure_stage_interface_pkg::IF_PC_WIDTH,
    parameter int INSTR_WIDTH = bure_stage_interface_pkg::IF_INSTR_WIDTH
);

    logic [INSTR_WIDTH-1:0] instr;
    logic                   instr_valid;
    logic [DATA_WIDTH-1:0]  pc;

    modport master (
        output instr,
        output instr_valid,
        output pc
    );

    modport slave (
        input instr,
        input instr_valid,
        input pc
    );

endinterface : bure_if_interface

// File: rtl/bure_fetch_fifo.sv
// -----------------------------------------------------------------------------
// bure_fetch_fifo
// Small synchronous FIFO holding fetched {pc, instr} entries.
//   clk, srst  : clock, synchronous active-high reset.
//   push/push_data : write one entry at the tail.
//   pop        : drop the head entry.
//   flush      : empty the queue; wins over push and pop.
//   head_data  : current head entry (valid when !empty).
//   count/empty/full : occupancy.
// The head is read straight from storage so decode sees it in the cycle
// after the push without an extra output register.
// -----------------------------------------------------------------------------
module bure_fetch_fifo #(
    parameter int WIDTH       = 64,
    parameter int DEPTH       = 2,
    parameter int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       head_data,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]       mem_reg [DEPTH];
    logic [AW-1:0]          wr_ptr_reg;
    logic [AW-1:0]          rd_ptr_reg;
    logic [COUNT_WIDTH-1:0] count_reg;
    logic                   do_push;
    logic                   do_pop;

    // Pointer increment that also works for non power-of-two depths.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == COUNT_WIDTH'(DEPTH));
    assign do_pop    = pop && !empty;
    // A push into a full queue is allowed only when the head leaves this cycle.
    assign do_push   = push && (!full || do_pop);
    assign count     = count_reg;
    assign head_data = mem_reg[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            count_reg <= count_reg + COUNT_WIDTH'(do_push) - COUNT_WIDTH'(do_pop);
        end
    end

    // Storage is not reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !srst) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

endmodule : bure_fetch_fifo

// File: rtl/bure_stage_if.sv
// -----------------------------------------------------------------------------
// bure_stage_if
// Instruction-fetch stage. Issues sequential word fetches, buffers in-order
// responses in bure_fetch_fifo and presents the head to decode.
//   i_clk, i_rst          : clock, synchronous active-high reset.
//   o_imem_req_valid/i_imem_req_ready/o_imem_addr : fetch request channel.
//   i_imem_rsp_valid/i_imem_rsp_data : in-order response beats (no backpressure).
//   i_redirect_valid/i_redirect_pc   : flush and restart fetch at a new PC.
//   i_stall               : decode does not take the head this cycle.
//   if_if                 : {instr, instr_valid, pc} towards decode.
// Credit: in-flight requests, stale beats still to drop and queued entries
// together never exceed FIFO_DEPTH, so every accepted response has a slot.
// -----------------------------------------------------------------------------
module bure_stage_if
    import bure_core_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = DATA_WIDTH'(DEFAULT_RESET_PC),
    parameter int                    FIFO_DEPTH  = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    output logic                   o_imem_req_valid,
    input  logic                   i_imem_req_ready,
    output logic [DATA_WIDTH-1:0]  o_imem_addr,
    input  logic                   i_imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] i_imem_rsp_data,
    input  logic                   i_redirect_valid,
    input  logic [DATA_WIDTH-1:0]  i_redirect_pc,
    input  logic                   i_stall,
    bure_if_interface.master       if_if
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = CW + 2;                  // room for the credit sum
    localparam int EW = DATA_WIDTH + INSTR_WIDTH;

    localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(INSTR_BYTES);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(INSTR_BYTES - 1);
    localparam logic [DATA_WIDTH-1:0] RESET_PC_A = RESET_PC & ALIGN_MASK;

    logic [DATA_WIDTH-1:0] fetch_pc_reg, fetch_pc_next;
    logic [DATA_WIDTH-1:0] rsp_pc_reg, rsp_pc_next;
    logic [CW-1:0]         outstanding_reg, outstanding_next;
    logic [CW-1:0]         drop_cnt_reg, drop_cnt_next;

    logic [CW-1:0]         fifo_count;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [EW-1:0]         fifo_head;

    logic                  out_valid;
    logic                  pop;
    logic [SW-1:0]         credit_used;
    logic                  req_valid;
    logic                  req_fire;
    logic                  rsp_drop;
    logic                  rsp_accept;
    logic                  push;
    logic                  rsp_consumed;
    logic [SW-1:0]         pending_total;
    logic [DATA_WIDTH-1:0] redirect_aligned;

    assign redirect_aligned = i_redirect_pc & ALIGN_MASK;

    assign out_valid = !i_rst && !fifo_empty;
    assign pop       = out_valid && !i_stall;

    // A slot freed by this cycle's pop can be promised to a new request:
    // its response cannot arrive before the next cycle. This is what lets a
    // two-entry queue sustain one fetch per cycle with 1-cycle memory.
    assign credit_used = SW'(outstanding_reg) + SW'(drop_cnt_reg)
                       + SW'(fifo_count) - SW'(pop);

    assign req_valid = !i_rst && !i_redirect_valid
                     && (credit_used < SW'(FIFO_DEPTH));
    assign req_fire  = req_valid && i_imem_req_ready;

    assign rsp_drop   = i_imem_rsp_valid && (drop_cnt_reg != '0);
    assign rsp_accept = i_imem_rsp_valid && (drop_cnt_reg == '0)
                      && (outstanding_reg != '0);
    assign push       = rsp_accept && !i_redirect_valid && (!fifo_full || pop);

    // On redirect every still-pending beat becomes stale; a beat arriving in
    // the redirect cycle itself is already consumed and is not counted.
    assign rsp_consumed  = i_imem_rsp_valid
                         && ((outstanding_reg != '0) || (drop_cnt_reg != '0));
    assign pending_total = SW'(outstanding_reg) + SW'(drop_cnt_reg)
                         - SW'(rsp_consumed);

    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        rsp_pc_next      = rsp_pc_reg;
        outstanding_next = outstanding_reg;
        drop_cnt_next    = drop_cnt_reg;
        if (i_redirect_valid) begin
            fetch_pc_next    = redirect_aligned;
            rsp_pc_next      = redirect_aligned;
            outstanding_next = '0;
            drop_cnt_next    = CW'(pending_total);
        end else begin
            if (req_fire) begin
                fetch_pc_next = fetch_pc_reg + PC_STEP;
            end
            if (rsp_accept) begin
                rsp_pc_next = rsp_pc_reg + PC_STEP;
            end
            outstanding_next = outstanding_reg + CW'(req_fire) - CW'(rsp_accept);
            if (rsp_drop) begin
                drop_cnt_next = drop_cnt_reg - CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_pc_reg    <= RESET_PC_A;
            rsp_pc_reg      <= RESET_PC_A;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            rsp_pc_reg      <= rsp_pc_next;
            outstanding_reg <= outstanding_next;
            drop_cnt_reg    <= drop_cnt_next;
        end
    end

    bure_fetch_fifo #(
        .WIDTH       (EW),
        .DEPTH       (FIFO_DEPTH),
        .COUNT_WIDTH (CW)
    ) u_fifo (
        .clk       (i_clk),
        .srst      (i_rst),
        .push      (push),
        .push_data ({rsp_pc_reg, i_imem_rsp_data}),
        .pop       (pop),
        .flush     (i_redirect_valid),
        .head_data (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign o_imem_req_valid = req_valid;
    assign o_imem_addr      = fetch_pc_reg;

    assign if_if.instr_valid = out_valid;
    assign if_if.pc          = fifo_head[EW-1:INSTR_WIDTH];
    assign if_if.instr       = fifo_head[INSTR_WIDTH-1:0];

    // A beat with nothing pending means the memory broke the protocol; the
    // beat is ignored. An accepted beat must always find a free slot.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert (!(i_imem_rsp_valid && (outstanding_reg == '0)
                      && (drop_cnt_reg == '0)));
            assert (!(rsp_accept && !i_redirect_valid && fifo_full && !pop));
        end
    end

endmodule : bure_stage_if

// File: tb/tb_bure_stage_if.sv
// -----------------------------------------------------------------------------
// tb_bure_stage_if
// Bench for the fetch stage: a memory model with programmable latency answers
// requests in order; every accepted request pushes its expected {pc, instr}
// into a queue which is popped and compared whenever decode takes an entry.
// -----------------------------------------------------------------------------
module tb_bure_stage_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;

    bure_if_interface fetch_if ();

    bure_stage_if dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .o_imem_req_valid (req_valid),
        .i_imem_req_ready (req_ready),
        .o_imem_addr      (addr),
        .i_imem_rsp_valid (rsp_valid),
        .i_imem_rsp_data  (rsp_data),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .i_stall          (stall),
        .if_if            (fetch_if)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          lat = 1;
    int          deliveries = 0;
    logic [31:0] model_fetch_pc;
    logic [63:0] exp_q[$];
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];

    logic        s_req_valid, s_instr_valid, s_fire, s_pop;
    logic [31:0] s_addr, s_pc, s_instr;

    function automatic logic [31:0] mem_func(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // One clock: sample at negedge, scoreboard, memory model, then return
    // just after the posedge so callers can set the next cycle's inputs.
    task automatic cycle();
        logic [63:0] e;
        @(negedge clk);
        s_req_valid   = req_valid;
        s_addr        = addr;
        s_instr_valid = fetch_if.instr_valid;
        s_pc          = fetch_if.pc;
        s_instr       = fetch_if.instr;
        s_fire        = req_valid && req_ready;
        s_pop         = fetch_if.instr_valid && !stall;
        if (rsp_valid && mem_addr_q.size() > 0) begin
            void'(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end
        if (!rst) begin
            if (s_fire) begin
                checks++;
                if (s_addr !== model_fetch_pc) begin
                    errors++;
                    $display("FAIL sb_addr cyc=%0d got=%h exp=%h", cyc, s_addr, model_fetch_pc);
                end
                exp_q.push_back({model_fetch_pc, mem_func(model_fetch_pc)});
                model_fetch_pc = model_fetch_pc + 32'd4;
                mem_addr_q.push_back(s_addr);
                mem_due_q.push_back(cyc + lat);
            end
            if (s_pop) begin
                checks++;
                deliveries++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected cyc=%0d got pc=%h instr=%h exp=none", cyc, s_pc, s_instr);
                end else begin
                    e = exp_q.pop_front();
                    if ({s_pc, s_instr} !== e) begin
                        errors++;
                        $display("FAIL sb_data cyc=%0d got pc=%h instr=%h exp pc=%h instr=%h",
                                 cyc, s_pc, s_instr, e[63:32], e[31:0]);
                    end else begin
                        $display("deliver cyc=%0d pc=%h instr=%h", cyc, s_pc, s_instr);
                    end
                end
            end
            if (redirect_valid) begin
                exp_q.delete();
                model_fetch_pc = redirect_pc & 32'hFFFF_FFFC;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = mem_func(mem_addr_q[0]);
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = '0;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        redirect_valid = 1'b0;
        stall = 1'b0;
        req_ready = 1'b1;
        mem_addr_q.delete();
        mem_due_q.delete();
        rsp_valid = 1'b0;
        repeat (n) cycle();
        rst = 1'b0;
        exp_q.delete();
        mem_addr_q.delete();
        mem_due_q.delete();
        rsp_valid = 1'b0;
        model_fetch_pc = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            cycle();
            checks++;
            if (s_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_req_valid got=%b exp=0", s_req_valid);
            end
            checks++;
            if (s_instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_instr_valid got=%b exp=0", s_instr_valid);
            end
        end
        rst = 1'b0;
        model_fetch_pc = 32'h0;
        $display("reset done cyc=%0d", cyc);
    endtask

    task automatic test_back_to_back();
        int d0;
        lat = 1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++;
            if (!(s_fire === 1'b1 && s_addr === 32'(k * 4))) begin
                errors++;
                $display("FAIL b2b_issue k=%0d got fire=%b addr=%h exp fire=1 addr=%h", k, s_fire, s_addr, 32'(k * 4));
            end
            checks++;
            if (k < 2) begin
                if (s_instr_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_early_valid k=%0d got=%b exp=0", k, s_instr_valid);
                end
            end else if (!(s_instr_valid === 1'b1 && s_pc === 32'h0)) begin
                errors++;
                $display("FAIL b2b_first_out got valid=%b pc=%h exp valid=1 pc=00000000", s_instr_valid, s_pc);
            end
        end
        d0 = deliveries;
        repeat (6) cycle();
        checks++;
        if (deliveries - d0 != 6) begin
            errors++;
            $display("FAIL b2b_throughput got=%0d exp=6", deliveries - d0);
        end
    endtask

    task automatic test_stall();
        int d0;
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (s_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_req_valid i=%0d got=%b exp=0", i, s_req_valid);
            end
            if (i >= 1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stall_head i=%0d got pc=%h exp=queued entry (none)", i, s_pc);
                end else if (!(s_instr_valid === 1'b1 && s_pc === exp_q[0][63:32]
                               && s_instr === exp_q[0][31:0])) begin
                    errors++;
                    $display("FAIL stall_head i=%0d got valid=%b pc=%h instr=%h exp valid=1 pc=%h instr=%h",
                             i, s_instr_valid, s_pc, s_instr, exp_q[0][63:32], exp_q[0][31:0]);
                end
            end
        end
        stall = 1'b0;
        d0 = deliveries;
        repeat (6) cycle();
        checks++;
        if (deliveries - d0 != 6) begin
            errors++;
            $display("FAIL stall_release got=%0d exp=6", deliveries - d0);
        end
    endtask

    task automatic test_ready_low();
        logic [31:0] held;
        held = model_fetch_pc;
        req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (!(s_req_valid === 1'b1 && s_addr === held)) begin
                errors++;
                $display("FAIL ready_low_hold i=%0d got valid=%b addr=%h exp valid=1 addr=%h", i, s_req_valid, s_addr, held);
            end
        end
        req_ready = 1'b1;
        cycle();
        checks++;
        if (!(s_fire === 1'b1 && s_addr === held)) begin
            errors++;
            $display("FAIL ready_resume got fire=%b addr=%h exp fire=1 addr=%h", s_fire, s_addr, held);
        end
        repeat (4) cycle();
    endtask

    task automatic test_redirect();
        logic        seen_req, seen_out;
        logic [31:0] first_req, first_out;
        do_reset(2);
        lat = 3;
        repeat (2) cycle();
        checks++;
        if (dut.outstanding_reg !== 2'd2) begin
            errors++;
            $display("FAIL redir_outstanding got=%0d exp=2", dut.outstanding_reg);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        cycle();
        redirect_valid = 1'b0;
        checks++;
        if (s_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_no_issue got=%b exp=0", s_req_valid);
        end
        checks++;
        if (dut.drop_cnt_reg !== 2'd2) begin
            errors++;
            $display("FAIL redir_drop_cnt got=%0d exp=2", dut.drop_cnt_reg);
        end
        seen_req = 0;
        seen_out = 0;
        first_req = '0;
        first_out = '0;
        for (int i = 0; i < 30 && !(seen_req && seen_out); i++) begin
            cycle();
            if (s_fire && !seen_req) begin seen_req = 1; first_req = s_addr; end
            if (s_pop && !seen_out) begin seen_out = 1; first_out = s_pc; end
        end
        checks++;
        if (!(seen_req && first_req === 32'h100)) begin
            errors++;
            $display("FAIL redir_first_req got seen=%b addr=%h exp addr=00000100", seen_req, first_req);
        end
        checks++;
        if (!(seen_out && first_out === 32'h100)) begin
            errors++;
            $display("FAIL redir_first_out got seen=%b pc=%h exp pc=00000100", seen_out, first_out);
        end
    endtask

    task automatic test_redirect_with_rsp();
        logic        seen_out;
        logic [31:0] first_out;
        do_reset(2);
        lat = 3;
        repeat (3) cycle();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        cycle();
        redirect_valid = 1'b0;
        checks++;
        if (dut.drop_cnt_reg !== 2'd1) begin
            errors++;
            $display("FAIL redir_rsp_drop_cnt got=%0d exp=1", dut.drop_cnt_reg);
        end
        seen_out = 0;
        first_out = '0;
        for (int i = 0; i < 30 && !seen_out; i++) begin
            cycle();
            if (s_pop) begin seen_out = 1; first_out = s_pc; end
        end
        checks++;
        if (!(seen_out && first_out === 32'h200)) begin
            errors++;
            $display("FAIL redir_rsp_first_out got seen=%b pc=%h exp pc=00000200", seen_out, first_out);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] reqs[$];
        logic [31:0] outs[$];
        lat = 1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        cycle();
        redirect_valid = 1'b0;
        for (int i = 0; i < 30 && !(reqs.size() >= 2 && outs.size() >= 2); i++) begin
            cycle();
            if (s_fire) reqs.push_back(s_addr);
            if (s_pop) outs.push_back(s_pc);
        end
        checks++;
        if (!(reqs.size() >= 2 && reqs[0] === 32'hFFFF_FFFC && reqs[1] === 32'h0)) begin
            errors++;
            $display("FAIL wrap_req got n=%0d first=%h second=%h exp fffffffc then 00000000",
                     reqs.size(), (reqs.size() > 0) ? reqs[0] : 32'hx, (reqs.size() > 1) ? reqs[1] : 32'hx);
        end
        checks++;
        if (!(outs.size() >= 2 && outs[0] === 32'hFFFF_FFFC && outs[1] === 32'h0)) begin
            errors++;
            $display("FAIL wrap_out got n=%0d first=%h second=%h exp fffffffc then 00000000",
                     outs.size(), (outs.size() > 0) ? outs[0] : 32'hx, (outs.size() > 1) ? outs[1] : 32'hx);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_ready = 1'b1;
        rsp_valid = 1'b0;
        rsp_data = '0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        stall = 1'b0;
        model_fetch_pc = 32'h0;
        test_reset();
        test_back_to_back();
        test_stall();
        test_ready_low();
        test_redirect();
        test_redirect_with_rsp();
        test_wrap();
        repeat (4) cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule : tb_bure_stage_if
